// File: rtl/tpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tpu_pkg                                                        |
// | Brief   : Shared types, defaults and helpers for the systolic MAC tiles. |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
package tpu_pkg;

    localparam int c_default_array_dim  = 4;
    localparam int c_default_data_width = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_IDLE = 2'd2,
        CAPTURE   = 2'd3
    } loader_state_t;

    // A one-row array still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_weight_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : systolic_weight_loader_if                                      |
// | Brief   : Valid/ready weight-row stream into the systolic weight loader. |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface systolic_weight_loader_if
    import tpu_pkg::*;
#(
    parameter int ARRAY_DIM  = c_default_array_dim,
    parameter int DATA_WIDTH = c_default_data_width
) ();

    logic                            wt_valid;
    logic                            wt_ready;
    logic [ARRAY_DIM*DATA_WIDTH-1:0] wt_data;

    modport master (
        output wt_valid,
        output wt_data,
        input  wt_ready
    );

    modport slave (
        input  wt_valid,
        input  wt_data,
        output wt_ready
    );

endinterface
`default_nettype wire

// File: rtl/systolic_weight_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : systolic_weight_loader                                         |
// | Brief   : Streams weight rows down the PE pass chains, then issues one   |
// |           simultaneous capture once the array is idle.                   |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module systolic_weight_loader
    import tpu_pkg::*;
#(
    parameter int ARRAY_DIM  = c_default_array_dim,
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    systolic_weight_loader_if.slave         wt_if,
    input  logic                            array_idle,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] weight_out,
    output logic                            en_weight_pass,
    output logic                            en_weight_capture,
    output logic                            busy,
    output logic                            done
);

    localparam int                  c_cnt_w    = cnt_width(ARRAY_DIM);
    localparam logic [c_cnt_w-1:0] c_last_row = c_cnt_w'(ARRAY_DIM - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    loader_state_t      r_state;
    logic [c_cnt_w-1:0] r_row_cnt;
    logic               w_hs;

    // Abort blocks the handshake so a cancelled row never reaches the chain.
    assign w_hs = (r_state == SHIFT) && wt_if.wt_valid && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_row_cnt      <= '0;
            weight_out     <= '0;
            en_weight_pass <= 1'b0;
        end else begin
            en_weight_pass <= w_hs;
            if (w_hs) begin
                weight_out <= wt_if.wt_data;
            end

            if (abort) begin
                r_state   <= IDLE;
                r_row_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state   <= SHIFT;
                            r_row_cnt <= '0;
                        end
                    end
                    SHIFT: begin
                        if (wt_if.wt_valid) begin
                            if (r_row_cnt == c_last_row) begin
                                r_state   <= WAIT_IDLE;
                                r_row_cnt <= '0;
                            end else begin
                                r_row_cnt <= r_row_cnt + c_one;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (array_idle) begin
                            r_state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Moore decode straight off the state flop.
    assign wt_if.wt_ready    = (r_state == SHIFT);
    assign busy              = (r_state != IDLE);
    assign en_weight_capture = (r_state == CAPTURE);
    assign done              = (r_state == CAPTURE);

endmodule
`default_nettype wire

// File: tb/tb_systolic_weight_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_systolic_weight_loader                                      |
// | Brief   : Self-checking bench with a PE-grid scoreboard for the loader.  |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_systolic_weight_loader;

    localparam int DIM = 4;
    localparam int DW  = 8;
    localparam int W   = DIM * DW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic         array_idle;
    logic [W-1:0] weight_out;
    logic         en_weight_pass;
    logic         en_weight_capture;
    logic         busy;
    logic         done;

    systolic_weight_loader_if #(.ARRAY_DIM(DIM), .DATA_WIDTH(DW)) wif ();

    systolic_weight_loader #(.ARRAY_DIM(DIM), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .abort             (abort),
        .wt_if             (wif),
        .array_idle        (array_idle),
        .weight_out        (weight_out),
        .en_weight_pass    (en_weight_pass),
        .en_weight_capture (en_weight_capture),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural PE grid: pass chains shift downward, capture latches all rows.
    logic [W-1:0] chain   [DIM];
    logic [W-1:0] cap_grid[DIM];
    int           n_pass = 0;
    int           n_cap  = 0;

    always @(posedge clk) begin
        if (en_weight_pass) begin
            n_pass <= n_pass + 1;
            chain[0] <= weight_out;
            for (int r = 1; r < DIM; r++) chain[r] <= chain[r-1];
        end
        if (en_weight_capture) begin
            n_cap <= n_cap + 1;
            for (int r = 0; r < DIM; r++) cap_grid[r] <= chain[r];
        end
    end

    logic [W-1:0] exp_wout = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, wif.wt_ready, 0);
        check({tag, "_cap"}, en_weight_capture, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, en_weight_pass, 0);
        check({tag, "_wout"}, weight_out, exp_wout);
    endtask

    // mode 0: back-to-back, 1: fixed 1,0,0,1,1,0,1 pattern, 2: random gaps.
    task automatic load(input int mode, input int dly, input bit noise, input bit fixed_rows);
        logic [W-1:0] sent[$];
        logic [W-1:0] basic[DIM];
        logic [6:0]   pat;
        bit           prev_hs;
        int           hs, it, nw, p0, c0;
        basic[0] = 32'h01020304; basic[1] = 32'h05060708;
        basic[2] = 32'h090A0B0C; basic[3] = 32'h0D0E0F10;
        pat = 7'b1011001;
        p0 = n_pass; c0 = n_cap;
        array_idle = (dly == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        hs = 0; it = 0; prev_hs = 0;
        while (hs < DIM && it < 100) begin
            check("shift_ready", wif.wt_ready, 1);
            check("shift_busy", busy, 1);
            check("shift_cap", en_weight_capture, 0);
            check("shift_pass", en_weight_pass, prev_hs);
            check("shift_wout", weight_out, exp_wout);
            case (mode)
                0:       wif.wt_valid = 1'b1;
                1:       wif.wt_valid = pat[it % 7];
                default: wif.wt_valid = 1'($urandom_range(0, 1));
            endcase
            wif.wt_data = (fixed_rows && hs < DIM) ? basic[hs] : W'($urandom);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            prev_hs = wif.wt_valid;
            if (wif.wt_valid) begin
                sent.push_back(wif.wt_data);
                exp_wout = wif.wt_data;
                hs++;
            end
            tick();
            it++;
        end
        wif.wt_valid = 1'b0;
        start = 1'b0;
        if (it >= 100) check("hs_budget", 64'(hs), 64'(DIM));
        nw = (dly < 1) ? 1 : dly;
        for (int i = 0; i < nw; i++) begin
            check("wait_ready", wif.wt_ready, 0);
            check("wait_busy", busy, 1);
            check("wait_cap", en_weight_capture, 0);
            check("wait_done", done, 0);
            check("wait_pass", en_weight_pass, (i == 0));
            check("wait_wout", weight_out, exp_wout);
            if (i == nw - 1) array_idle = 1'b1;
            tick();
        end
        check("cap_cap", en_weight_capture, 1);
        check("cap_done", done, 1);
        check("cap_busy", busy, 1);
        check("cap_pass", en_weight_pass, 0);
        check("pass_count", 64'(n_pass - p0), 64'(DIM));
        array_idle = 1'($urandom_range(0, 1));
        tick();
        check_quiet("post_cap");
        check("cap_count", 64'(n_cap - c0), 1);
        for (int r = 0; r < DIM; r++) begin
            if (sent.size() == DIM) check("grid_row", cap_grid[r], sent[DIM-1-r]);
        end
        array_idle = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [W-1:0] d;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; array_idle = 1'b1;
        wif.wt_valid = 1'b0; wif.wt_data = '0;
        #12;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_quiet("after_reset");

        load(0, 0, 0, 1);   // basic load, minimum latency
        load(1, 0, 0, 0);   // stalled source
        load(0, 10, 0, 0);  // array busy for 10 cycles

        // Abort coincident with the third handshake.
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wif.wt_valid = 1'b1; d = W'($urandom); wif.wt_data = d; exp_wout = d;
            tick();
        end
        check("abort_pre_pass", en_weight_pass, 1);
        abort = 1'b1; wif.wt_data = W'($urandom);
        tick();
        abort = 1'b0; wif.wt_valid = 1'b0;
        check_quiet("abort");
        c0 = n_cap;
        repeat (3) tick();
        check_quiet("abort_idle");
        check("abort_no_cap", 64'(n_cap - c0), 0);
        load(0, 0, 0, 0);

        // start and abort together in IDLE.
        start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0;
        check_quiet("start_abort");
        tick();
        check_quiet("start_abort2");

        load(2, 0, 1, 0);   // start noise during SHIFT is ignored

        // Asynchronous reset while parked in WAIT_IDLE.
        array_idle = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wif.wt_valid = 1'b1;
        for (int k = 0; k < DIM; k++) begin
            wif.wt_data = W'($urandom);
            tick();
        end
        wif.wt_valid = 1'b0;
        tick();
        check("rst_pre_busy", busy, 1);
        c0 = n_cap;
        #2 rst_n = 1'b0;
        #1;
        exp_wout = '0;
        check_quiet("async_rst");
        @(posedge clk);
        #1 array_idle = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_quiet("post_rst");
        end
        check("rst_no_cap", 64'(n_cap - c0), 0);

        for (int k = 0; k < 4; k++) begin
            load(2, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_weight_loader.md
Name: systolic_weight_loader

Overview:
- Sequences weight loading into one ARRAY_DIM x ARRAY_DIM systolic MAC array. Sits directly upstream of the PE grid's weight ports.
- Accepts a stream of weight rows over a valid/ready handshake and shifts them down the per-column pass chain with en_weight_pass.
- Waits until the array reports idle, then issues a single-cycle en_weight_capture so every PE latches its weight simultaneously.

Parameters:
ARRAY_DIM, 4, rows/columns of the systolic array (>=1)
DATA_WIDTH, 8, signed weight width per PE

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request to begin a load; honoured only in IDLE
abort  input  1  synchronous cancel; returns to IDLE, no capture
wt_valid  input  1  wt_data valid
wt_ready  output  1  loader accepts a row this cycle
wt_data  input  ARRAY_DIM*DATA_WIDTH  one weight row; column c at bits [c*DATA_WIDTH +: DATA_WIDTH]
array_idle  input  1  array not computing; capture is legal
weight_out  output  ARRAY_DIM*DATA_WIDTH  row driven into top of the column pass chains
en_weight_pass  output  1  shift pass chains one row down
en_weight_capture  output  1  all PEs latch weight_in into the weight register
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, coincident with en_weight_capture

Behaviour:
Reset values:
- All outputs are 0.
- weight_out is all-zero.
- State is IDLE and row_cnt is 0.

FSM states: IDLE, SHIFT, WAIT_IDLE, CAPTURE. The state register is a flop. wt_ready, busy, en_weight_capture and done decode from state (Moore).

IDLE:
- wt_ready=0.
- start=1 and abort=0 -> SHIFT, row_cnt<=0.

SHIFT:
- wt_ready=1.
- On handshake (wt_valid & wt_ready):
  - weight_out<=wt_data.
  - en_weight_pass<=1; it is a flop, so it is high in the following cycle.
  - row_cnt++.
- No handshake -> en_weight_pass<=0; weight_out holds.
- Handshake with row_cnt==ARRAY_DIM-1 -> WAIT_IDLE.

WAIT_IDLE:
- wt_ready=0. en_weight_pass is 0, except the registered pulse for the final row in the first cycle.
- array_idle=1 -> CAPTURE. Otherwise stay; there is no timeout.

CAPTURE:
- en_weight_capture=1 and done=1 for exactly one cycle.
- -> IDLE.

Row ordering:
- The first accepted row is delivered to PE row ARRAY_DIM-1 (bottom).
- The last accepted row is delivered to PE row 0.
- The upstream source must send rows bottom-first.

Minimum latency (wt_valid held 1, array_idle=1):
- start at cycle 0.
- Handshakes at cycles 1..ARRAY_DIM.
- en_weight_pass high at cycles 2..ARRAY_DIM+1.
- Capture/done at cycle ARRAY_DIM+2.
- busy drops at cycle ARRAY_DIM+3.

Boundaries:
- start while busy: ignored.
- abort in any state: next state IDLE, row_cnt<=0, en_weight_pass<=0, no capture, no done. weight_out holds its last value.
- abort and start in the same cycle in IDLE: abort wins, stay IDLE.
- abort coincident with a SHIFT handshake: the row is not passed (abort has priority).
- wt_valid gaps in SHIFT: no pass pulse and the chain holds. Capture never occurs before exactly ARRAY_DIM passes.
- array_idle dropping in CAPTURE: capture still completes. It is only sampled in WAIT_IDLE.
- ARRAY_DIM=1: row_cnt width is 1 bit; a single handshake -> WAIT_IDLE.
- rst_n asserted mid-load: immediate return to reset values, with no capture pulse.

Decomposition:
- Shared package tpu_pkg holds:
  - the loader_state_t enum (IDLE, SHIFT, WAIT_IDLE, CAPTURE);
  - the function cnt_width(n) = max(1, $clog2(n));
  - the ARRAY_DIM and DATA_WIDTH defaults shared with the PE and the array top.
- No sub-module is natural: the FSM, row counter and output registers form one module (~150 lines).

Test Plan:
- Basic load: ARRAY_DIM=4, rows 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 streamed back-to-back, array_idle=1.
  - en_weight_pass high at cycles 2-5.
  - weight_out sequence matches the input rows.
  - capture/done pulse at cycle 6; busy low at cycle 7.
  - Scoreboard PE grid: row 3 = 0x01020304, row 0 = 0x0D0E0F10.
- Stalled source: wt_valid toggles 1,0,0,1,1,0,1.
  - Exactly 4 pass pulses, each one cycle after a handshake.
  - No capture until the 4th handshake plus 2 cycles.
- Array busy: array_idle=0 for 10 cycles after the last row.
  - Loader sits in WAIT_IDLE with wt_ready=0 and capture=0.
  - Capture fires exactly 1 cycle after array_idle rises.
- Abort: abort after the 2nd handshake.
  - busy=0 next cycle; no capture or done.
  - A subsequent start plus 4 rows completes normally with correct grid contents.
- Start/abort collisions:
  - start+abort together in IDLE -> stays IDLE.
  - start pulsed during SHIFT -> ignored; row_cnt unaffected.
- Async reset: rst_n low for 1 cycle during WAIT_IDLE.
  - All outputs 0 immediately.
  - No capture after release; the loader waits for a new start.
